// File: rtl/alu_sequencer.sv
// Initiator for an external ALU: accepts a command, holds operands for SETTLE cycles,
// captures Y and flags, then offers them downstream with a saturating count and sticky C/V.
module alu_sequencer #(
  parameter int A_W    = 2,
  parameter int B_W    = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [A_W-1:0]   cmd_a,
  input  logic [B_W-1:0]   cmd_b,
  input  logic [1:0]       cmd_op,
  output logic [A_W-1:0]   alu_a,
  output logic [B_W-1:0]   alu_b,
  output logic [1:0]       alu_op,
  input  logic [B_W-1:0]   alu_y,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [B_W-1:0]   res_y,
  output logic [3:0]       res_flags,
  output logic [1:0]       res_op,
  output logic [CNT_W-1:0] op_count,
  output logic             sticky_c,
  output logic             sticky_v,
  input  logic             clr_sticky
);

  typedef enum logic [1:0] {INIT, IDLE, SETTLE_WAIT, RESULT} state_t;

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t     state;
  logic [3:0] settle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      settle_cnt <= '0;
      cmd_ready  <= 1'b0;
      res_valid  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      res_y      <= '0;
      res_flags  <= '0;
      res_op     <= '0;
      op_count   <= '0;
      sticky_c   <= 1'b0;
      sticky_v   <= 1'b0;
    end else begin
      // A clear is overridden below if the same edge captures a set flag.
      if (clr_sticky) begin
        sticky_c <= 1'b0;
        sticky_v <= 1'b0;
      end
      case (state)
        INIT: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_op     <= cmd_op;
            settle_cnt <= SETTLE_LOAD;
            cmd_ready  <= 1'b0;
            state      <= SETTLE_WAIT;
          end
        end
        SETTLE_WAIT: begin
          if (settle_cnt == 4'd0) begin
            res_y     <= alu_y;
            res_flags <= {alu_z, alu_n, alu_c, alu_v};
            res_op    <= alu_op;
            res_valid <= 1'b1;
            state     <= RESULT;
            if (alu_c) sticky_c <= 1'b1;
            if (alu_v) sticky_v <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (op_count != CNT_MAX) op_count <= op_count + CNT_W'(1);
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: two sequencer instances (SETTLE=1/CNT_W=8 and SETTLE=3/CNT_W=2)
// driven by table vectors, hand sequences and random ops against a transaction-level model.
module tb_alu_sequencer;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid [N];
  logic       cmd_ready [N];
  logic [1:0] cmd_a     [N];
  logic [3:0] cmd_b     [N];
  logic [1:0] cmd_op    [N];
  logic [1:0] alu_a     [N];
  logic [3:0] alu_b     [N];
  logic [1:0] alu_op    [N];
  logic [3:0] alu_y     [N];
  logic [3:0] stub_fl   [N];
  logic       res_valid [N];
  logic       res_ready [N];
  logic [3:0] res_y     [N];
  logic [3:0] res_flags [N];
  logic [1:0] res_op    [N];
  logic       sticky_c  [N];
  logic       sticky_v  [N];
  logic       clr_sticky[N];
  logic [7:0] op_count0;
  logic [1:0] op_count1;

  alu_sequencer #(.A_W(2), .B_W(4), .SETTLE(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_op(cmd_op[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]),
    .alu_y(alu_y[0]), .alu_z(stub_fl[0][3]), .alu_n(stub_fl[0][2]),
    .alu_c(stub_fl[0][1]), .alu_v(stub_fl[0][0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .res_y(res_y[0]), .res_flags(res_flags[0]), .res_op(res_op[0]),
    .op_count(op_count0), .sticky_c(sticky_c[0]), .sticky_v(sticky_v[0]),
    .clr_sticky(clr_sticky[0])
  );

  alu_sequencer #(.A_W(2), .B_W(4), .SETTLE(3), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_op(cmd_op[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]),
    .alu_y(alu_y[1]), .alu_z(stub_fl[1][3]), .alu_n(stub_fl[1][2]),
    .alu_c(stub_fl[1][1]), .alu_v(stub_fl[1][0]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .res_y(res_y[1]), .res_flags(res_flags[1]), .res_op(res_op[1]),
    .op_count(op_count1), .sticky_c(sticky_c[1]), .sticky_v(sticky_v[1]),
    .clr_sticky(clr_sticky[1])
  );

  int total = 0;
  int bad = 0;

  // Transaction-level model: completed handshakes and sticky flags per instance
  int m_count [N];
  bit m_sc    [N];
  bit m_sv    [N];

  typedef struct {
    logic [1:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] stub_y;
    logic [3:0] stub_fl;
    int         hold;
    bit         clr;
    logic [3:0] exp_y;
    logic [3:0] exp_fl;
    int         exp_count;
    bit         exp_sc;
    bit         exp_sv;
  } vec_t;

  vec_t vecs [5];

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int count_max(input int i);
    return (i == 0) ? 255 : 3;
  endfunction

  function automatic logic [31:0] count_of(input int i);
    return (i == 0) ? 32'(op_count0) : 32'(op_count1);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input int i);
    check_output("rst_cmd_ready", cmd_ready[i], 0);
    check_output("rst_res_valid", res_valid[i], 0);
    check_output("rst_alu_a", alu_a[i], 0);
    check_output("rst_alu_b", alu_b[i], 0);
    check_output("rst_alu_op", alu_op[i], 0);
    check_output("rst_res_y", res_y[i], 0);
    check_output("rst_res_flags", res_flags[i], 0);
    check_output("rst_res_op", res_op[i], 0);
    check_output("rst_op_count", count_of(i), 0);
    check_output("rst_sticky_c", sticky_c[i], 0);
    check_output("rst_sticky_v", sticky_v[i], 0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      cmd_valid[i] = 0; cmd_a[i] = 0; cmd_b[i] = 0; cmd_op[i] = 0;
      alu_y[i] = 4'hF; stub_fl[i] = 4'hF;
      res_ready[i] = 0; clr_sticky[i] = 0;
      m_count[i] = 0; m_sc[i] = 0; m_sv[i] = 0;
    end
    repeat (3) tick;
    for (int i = 0; i < N; i++) check_all_zero(i);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < N; i++) check_output("init_cmd_ready_low", cmd_ready[i], 0);
    tick;
    for (int i = 0; i < N; i++) check_output("init_cmd_ready_high", cmd_ready[i], 1);
  endtask

  // One full command/result transaction; the stub shows the real result only during
  // the SETTLE-th cycle after the accept edge and junk everywhere else.
  task automatic apply_stimulus(input int i, input logic [1:0] a, input logic [3:0] b,
                                input logic [1:0] op, input logic [3:0] y, input logic [3:0] fl,
                                input int hold, input bit clr_cap);
    int s = settle_of(i);
    check_output("cmd_ready_idle", cmd_ready[i], 1);
    cmd_a[i] = a; cmd_b[i] = b; cmd_op[i] = op; cmd_valid[i] = 1;
    alu_y[i] = ~y; stub_fl[i] = ~fl;
    tick;
    cmd_valid[i] = 0; cmd_a[i] = ~a; cmd_b[i] = ~b; cmd_op[i] = ~op;
    for (int c = 1; c <= s; c++) begin
      check_output("settle_alu_a", alu_a[i], a);
      check_output("settle_alu_b", alu_b[i], b);
      check_output("settle_alu_op", alu_op[i], op);
      check_output("settle_cmd_ready", cmd_ready[i], 0);
      check_output("settle_res_valid", res_valid[i], 0);
      res_ready[i] = 1'($urandom_range(0, 1));
      if (c == s) begin
        alu_y[i] = y; stub_fl[i] = fl; clr_sticky[i] = clr_cap;
      end else begin
        alu_y[i] = y ^ 4'(1 + $urandom_range(0, 14)); stub_fl[i] = ~fl;
      end
      tick;
    end
    clr_sticky[i] = 0; res_ready[i] = 0;
    alu_y[i] = ~y; stub_fl[i] = ~fl;
    if (clr_cap) begin m_sc[i] = 0; m_sv[i] = 0; end
    m_sc[i] = m_sc[i] | fl[1];
    m_sv[i] = m_sv[i] | fl[0];
    check_output("cap_res_valid", res_valid[i], 1);
    check_output("cap_res_y", res_y[i], y);
    check_output("cap_res_flags", res_flags[i], fl);
    check_output("cap_res_op", res_op[i], op);
    check_output("cap_sticky_c", sticky_c[i], m_sc[i]);
    check_output("cap_sticky_v", sticky_v[i], m_sv[i]);
    check_output("cap_op_count", count_of(i), m_count[i]);
    check_output("cap_cmd_ready", cmd_ready[i], 0);
    for (int h = 0; h < hold; h++) begin
      cmd_valid[i] = 1; cmd_a[i] = 2'($urandom); cmd_b[i] = 4'($urandom); cmd_op[i] = 2'($urandom);
      alu_y[i] = 4'($urandom); stub_fl[i] = 4'($urandom);
      tick;
      check_output("bp_res_valid", res_valid[i], 1);
      check_output("bp_res_y", res_y[i], y);
      check_output("bp_res_flags", res_flags[i], fl);
      check_output("bp_cmd_ready", cmd_ready[i], 0);
      check_output("bp_alu_a", alu_a[i], a);
      check_output("bp_alu_b", alu_b[i], b);
    end
    res_ready[i] = 1;
    tick;
    res_ready[i] = 0; cmd_valid[i] = 0;
    m_count[i] = (m_count[i] + 1 > count_max(i)) ? count_max(i) : m_count[i] + 1;
    check_output("hs_res_valid", res_valid[i], 0);
    check_output("hs_cmd_ready", cmd_ready[i], 1);
    check_output("hs_op_count", count_of(i), m_count[i]);
    check_output("hs_res_y_kept", res_y[i], y);
    check_output("hs_alu_op_kept", alu_op[i], op);
  endtask

  initial begin
    int exp_cnt1 [5];
    do_reset;

    // Vectors for the SETTLE=1 instance, counts and stickies derived by hand from a fresh reset
    vecs[0] = '{2'b01, 4'b1010, 2'b01, 4'b1011, 4'b0100, 0, 0, 4'b1011, 4'b0100, 1, 0, 0};
    vecs[1] = '{2'b11, 4'b0101, 2'b10, 4'b1111, 4'b0010, 5, 0, 4'b1111, 4'b0010, 2, 1, 0};
    vecs[2] = '{2'b10, 4'b0011, 2'b00, 4'b0010, 4'b0000, 1, 0, 4'b0010, 4'b0000, 3, 1, 0};
    vecs[3] = '{2'b00, 4'b1000, 2'b11, 4'b1000, 4'b0100, 2, 0, 4'b1000, 4'b0100, 4, 1, 0};
    vecs[4] = '{2'b01, 4'b0001, 2'b11, 4'b0000, 4'b1001, 0, 1, 4'b0000, 4'b1001, 5, 0, 1};
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(0, vecs[k].a, vecs[k].b, vecs[k].op, vecs[k].stub_y, vecs[k].stub_fl,
                     vecs[k].hold, vecs[k].clr);
      check_output("vec_res_y", res_y[0], vecs[k].exp_y);
      check_output("vec_res_flags", res_flags[0], vecs[k].exp_fl);
      check_output("vec_op_count", count_of(0), vecs[k].exp_count);
      check_output("vec_sticky_c", sticky_c[0], vecs[k].exp_sc);
      check_output("vec_sticky_v", sticky_v[0], vecs[k].exp_sv);
    end

    // Clear outside a capture edge wipes both sticky bits
    clr_sticky[0] = 1;
    tick;
    clr_sticky[0] = 0;
    m_sc[0] = 0; m_sv[0] = 0;
    check_output("clr_idle_sticky_c", sticky_c[0], 0);
    check_output("clr_idle_sticky_v", sticky_v[0], 0);

    // SETTLE=3 with a 2-bit counter: saturation after three handshakes
    exp_cnt1 = '{1, 2, 3, 3, 3};
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1, 2'($urandom), 4'($urandom), 2'($urandom), 4'($urandom), 4'($urandom),
                     $urandom_range(0, 2), 0);
      check_output("sat_op_count", count_of(1), exp_cnt1[k]);
    end

    // Random transactions on either instance
    for (int k = 0; k < 30; k++) begin
      apply_stimulus($urandom_range(0, 1), 2'($urandom), 4'($urandom), 2'($urandom),
                     4'($urandom), 4'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of the settle window discards the operation
    do_reset;
    cmd_a[1] = 2'b11; cmd_b[1] = 4'hF; cmd_op[1] = 2'b10; cmd_valid[1] = 1;
    alu_y[1] = 4'hA; stub_fl[1] = 4'b0011;
    tick;
    cmd_valid[1] = 0;
    tick;
    check_output("midop_alu_a_before", alu_a[1], 2'b11);
    rst_n = 1'b0;
    #1;
    check_output("midop_res_valid", res_valid[1], 0);
    check_output("midop_alu_a", alu_a[1], 0);
    check_output("midop_alu_b", alu_b[1], 0);
    check_output("midop_alu_op", alu_op[1], 0);
    check_output("midop_op_count", count_of(1), 0);
    check_output("midop_cmd_ready", cmd_ready[1], 0);
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    check_output("midop_after_res_valid", res_valid[1], 0);
    check_output("midop_after_op_count", count_of(1), 0);
    check_output("midop_after_sticky_c", sticky_c[1], 0);
    check_output("midop_after_cmd_ready", cmd_ready[1], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Initiator side of the ALU operand/result interface. The block accepts operation commands (A, B, op) over a valid/ready handshake and drives them onto the ALU inputs. It holds the operands stable for a programmable settle time, then captures Y and the Z/N/C/V flags and presents them to a downstream consumer over a second valid/ready handshake. It also keeps a saturating operation count and sticky carry/overflow indicators for the control/debug path.

Parameters:
A_W, 2, width of operand A / alu_a
B_W, 4, width of operand B / alu_b and of result Y
SETTLE, 1, full cycles operands are held on alu_* before capture (legal range 1..15)
CNT_W, 8, width of op_count

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_a  in  A_W  operand A
cmd_b  in  B_W  operand B
cmd_op  in  2  00 AND, 01 XOR, 10 MULT, 11 SUB
alu_a  out  A_W  operand A to ALU
alu_b  out  B_W  operand B to ALU
alu_op  out  2  opcode to ALU
alu_y  in  B_W  ALU result
alu_z, alu_n, alu_c, alu_v  in  1 each  ALU flags
res_valid  out  1  captured result available
res_ready  in  1  consumer takes result
res_y  out  B_W  captured Y
res_flags  out  4  captured {Z,N,C,V}
res_op  out  2  opcode that produced res_y
op_count  out  CNT_W  completed result handshakes, saturating
sticky_c, sticky_v  out  1 each  set when any captured C/V = 1
clr_sticky  in  1  synchronous clear of sticky_c/sticky_v

Behaviour:
- Reset (rst_n=0, async):
  - state=INIT; cmd_ready=0, res_valid=0.
  - alu_a/alu_b/alu_op/res_y/res_flags/res_op/op_count/sticky_* = 0.
- All outputs are registered. There is no combinational path from any input to any output.
- States: INIT, IDLE, SETTLE_WAIT, RESULT.
- INIT -> IDLE on the first edge after rst_n rises. cmd_ready=1 only in IDLE.
- IDLE, accepting edge k (cmd_valid & cmd_ready):
  - latch cmd_* into alu_*; load settle counter to SETTLE-1; go SETTLE_WAIT; cmd_ready drops after edge k.
- SETTLE_WAIT:
  - alu_* constant. Decrement counter each edge.
  - At the edge where counter==0 (edge k+SETTLE): capture alu_y/flags into res_y/res_flags, alu_op into res_op; res_valid=1; go RESULT.
- Capture latency: accept edge k -> res_valid high after edge k+SETTLE.
- RESULT:
  - res_* held stable while res_valid=1 & res_ready=0 (indefinite backpressure).
  - On res_valid & res_ready: res_valid=0, op_count+1 (saturates at 2^CNT_W-1, no wrap), go IDLE. cmd_ready=1 after that edge.
  - No same-cycle command bypass. Max throughput is 1 op per SETTLE+2 cycles.
- alu_* keep their last values in IDLE/RESULT. They are never cleared except by reset.
- res_* keep their last values after the handshake until the next capture.
- sticky_c/sticky_v:
  - set at the capture edge if captured C/V=1.
  - clr_sticky clears them at the next edge.
  - If a clear and a set occur on the same edge, set wins.
- cmd_valid in non-IDLE states is ignored (cmd_ready=0); the command is not lost because the producer holds it.
- res_ready while res_valid=0 has no effect.
- Reset mid-operation (any state) aborts immediately to reset values. The pending result is discarded and op_count is not incremented.

Test Plan:
- Reset/INIT: hold rst_n=0 3 cycles -> all outputs 0, cmd_ready=0. Release -> cmd_ready=1 exactly 1 edge later.
- Single op, SETTLE=1, ALU stub returns Y=1011, flags=0100: send A=01 B=1010 op=01 -> alu_a=01 alu_b=1010 alu_op=01 one cycle. res_valid after accept edge +1; res_y=1011 res_flags=0100 res_op=01; op_count=1.
- Backpressure: hold res_ready=0 for 5 cycles, stub changes Y meanwhile -> res_y/res_flags unchanged, cmd_ready=0 throughout, cmd_valid=1 ignored. Raise res_ready -> one handshake, cmd_ready=1 next cycle.
- Settle timing, SETTLE=3: stub output changes each cycle -> captured value equals stub output on the 3rd cycle after the accept edge; alu_* stable all 3 cycles.
- Sticky/saturation:
  - stub C=1 on op2 of 4 -> sticky_c=1 through op4.
  - clr_sticky pulsed on a capture edge with V=1 -> sticky_v=1 (set wins).
  - CNT_W=2, 5 ops -> op_count 1,2,3,3,3.
- Reset mid-op: assert rst_n=0 in SETTLE_WAIT -> res_valid stays 0, op_count unchanged at 0, alu_*=0.
